// File: rtl/alarm_ctrl.sv
// -----------------------------------------------------------------------------
// alarm_ctrl -- alarm-clock ringing / snooze controller
//
// Watches the current time against the programmed alarm time. When the time
// steps into the alarm minute (rising edge of the match) with the alarm armed,
// the buzzer rings for RING_SECONDS tick_1hz pulses, then stops by itself.
// With the optional snooze feature a snooze pulse silences the buzzer for
// SNOOZE_SECONDS ticks, after which it rings again.
//
// Optional feature macro: ALARM_SNOOZE_EN (snooze state, snz_cnt and
// SNOOZE_SECONDS behaviour are compiled in only when it is defined).
//
// Ports
//   clk            in   system clock, all state on rising edge
//   rst            in   asynchronous active-low reset
//   tick_1hz       in   one-cycle pulse per second
//   hours          in   [4:0] current hour 0..23
//   minutes        in   [5:0] current minute 0..59
//   alarm_hours    in   [4:0] programmed alarm hour
//   alarm_minutes  in   [5:0] programmed alarm minute
//   alarm_en       in   alarm armed (level)
//   stop           in   one-cycle pulse, cancels the alarm
//   snooze         in   one-cycle pulse, defers the alarm
//   buzzer         out  high while ringing
//   alarm_active   out  high while ringing or snoozing
//   snoozing       out  high while snoozing
// -----------------------------------------------------------------------------
module alarm_ctrl #(
    parameter int RING_SECONDS   = 60,
    parameter int SNOOZE_SECONDS = 300
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic [4:0] hours,
    input  logic [5:0] minutes,
    input  logic [4:0] alarm_hours,
    input  logic [5:0] alarm_minutes,
    input  logic       alarm_en,
    input  logic       stop,
    input  logic       snooze,
    output logic       buzzer,
    output logic       alarm_active,
    output logic       snoozing
);

    localparam int RING_W = (RING_SECONDS > 1) ? $clog2(RING_SECONDS) : 1;
    localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_SECONDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RINGING = 2'd1,
        ST_SNOOZE  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [RING_W-1:0] ring_cnt_q, ring_cnt_d;
    logic              match, match_q, trigger;

    // Only the edge into the alarm minute triggers; arming mid-minute or
    // leaving a stopped alarm within the same minute never re-rings.
    assign match   = (hours == alarm_hours) && (minutes == alarm_minutes);
    assign trigger = alarm_en && match && !match_q;

`ifdef ALARM_SNOOZE_EN
    localparam int SNZ_W = (SNOOZE_SECONDS > 1) ? $clog2(SNOOZE_SECONDS) : 1;
    localparam logic [SNZ_W-1:0] SNZ_LAST = SNZ_W'(SNOOZE_SECONDS - 1);

    logic [SNZ_W-1:0] snz_cnt_q, snz_cnt_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            snz_cnt_q <= '0;
        end else begin
            snz_cnt_q <= snz_cnt_d;
        end
    end
`else
    // Snooze is compiled out: the pulse and its period have no effect.
    logic unused_snooze;
    assign unused_snooze = snooze | (SNOOZE_SECONDS == 0);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            ring_cnt_q <= '0;
            // Starts high so releasing reset inside the alarm minute does
            // not look like a fresh match edge.
            match_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            ring_cnt_q <= ring_cnt_d;
            match_q    <= match;
        end
    end

    // Priority inside an active state: alarm_en low > stop > snooze > expiry.
    always_comb begin
        state_d    = state_q;
        ring_cnt_d = ring_cnt_q;
`ifdef ALARM_SNOOZE_EN
        snz_cnt_d  = snz_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (trigger) begin
                    state_d    = ST_RINGING;
                    ring_cnt_d = '0;
                end
            end
            ST_RINGING: begin
                if (!alarm_en || stop) begin
                    state_d = ST_IDLE;
`ifdef ALARM_SNOOZE_EN
                end else if (snooze) begin
                    state_d   = ST_SNOOZE;
                    snz_cnt_d = '0;
`endif
                end else if (tick_1hz) begin
                    if (ring_cnt_q == RING_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        ring_cnt_d = ring_cnt_q + 1'b1;
                    end
                end
            end
`ifdef ALARM_SNOOZE_EN
            ST_SNOOZE: begin
                // Repeated snooze pulses fall through and do not restart
                // the snooze period.
                if (!alarm_en || stop) begin
                    state_d = ST_IDLE;
                end else if (tick_1hz) begin
                    if (snz_cnt_q == SNZ_LAST) begin
                        state_d    = ST_RINGING;
                        ring_cnt_d = '0;
                    end else begin
                        snz_cnt_d = snz_cnt_q + 1'b1;
                    end
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are pure decodes of the state register.
    assign buzzer       = (state_q == ST_RINGING);
`ifdef ALARM_SNOOZE_EN
    assign snoozing     = (state_q == ST_SNOOZE);
    assign alarm_active = (state_q == ST_RINGING) || (state_q == ST_SNOOZE);
`else
    assign snoozing     = 1'b0;
    assign alarm_active = (state_q == ST_RINGING);
`endif

endmodule

// File: tb/tb_alarm_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alarm_ctrl -- self-checking bench for alarm_ctrl (RING_SECONDS=4,
// SNOOZE_SECONDS=3). Snooze expectations follow ALARM_SNOOZE_EN as seen by
// this file.
// -----------------------------------------------------------------------------
module tb_alarm_ctrl;

    localparam int RS = 4;
    localparam int SS = 3;
`ifdef ALARM_SNOOZE_EN
    localparam bit SNZ_ON = 1'b1;
`else
    localparam bit SNZ_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick_1hz = 1'b0;
    logic [4:0] hours = 5'd7;
    logic [5:0] minutes = 6'd29;
    logic [4:0] alarm_hours = 5'd7;
    logic [5:0] alarm_minutes = 6'd30;
    logic       alarm_en = 1'b1;
    logic       stop = 1'b0;
    logic       snooze = 1'b0;
    logic       buzzer, alarm_active, snoozing;

    int checks = 0;
    int errors = 0;

    alarm_ctrl #(.RING_SECONDS(RS), .SNOOZE_SECONDS(SS)) dut (
        .clk           (clk),
        .rst           (rst),
        .tick_1hz      (tick_1hz),
        .hours         (hours),
        .minutes       (minutes),
        .alarm_hours   (alarm_hours),
        .alarm_minutes (alarm_minutes),
        .alarm_en      (alarm_en),
        .stop          (stop),
        .snooze        (snooze),
        .buzzer        (buzzer),
        .alarm_active  (alarm_active),
        .snoozing      (snoozing)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // mode: 0 quiet, 1 ringing, 2 snoozing; counters hold seconds remaining.
    int m_mode = 0;
    int m_ring_left = 0;
    int m_snz_left = 0;
    bit m_prev_match = 1'b1;

    task automatic model_reset();
        m_mode = 0;
        m_ring_left = 0;
        m_snz_left = 0;
        m_prev_match = 1'b1;
    endtask

    // Advance the model by one clock edge using the inputs now applied.
    task automatic model_edge();
        bit match, trig;
        match = (hours == alarm_hours) && (minutes == alarm_minutes);
        trig  = alarm_en && match && !m_prev_match;
        if (m_mode == 0) begin
            if (trig) begin
                m_mode = 1;
                m_ring_left = RS;
            end
        end else if (!alarm_en || stop) begin
            m_mode = 0;
        end else if (m_mode == 1) begin
            if (snooze && SNZ_ON) begin
                m_mode = 2;
                m_snz_left = SS;
            end else if (tick_1hz) begin
                m_ring_left--;
                if (m_ring_left == 0) m_mode = 0;
            end
        end else begin
            if (tick_1hz) begin
                m_snz_left--;
                if (m_snz_left == 0) begin
                    m_mode = 1;
                    m_ring_left = RS;
                end
            end
        end
        m_prev_match = match;
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: {buzzer,active,snoozing} got %b expected %b", name, act, exp);
        end
    endtask

    task automatic setin(input bit en, input int h, input int m,
                         input bit t, input bit st, input bit sz);
        alarm_en = en;
        hours    = 5'(h);
        minutes  = 6'(m);
        tick_1hz = t;
        stop     = st;
        snooze   = sz;
    endtask

    // One clock: model advances on the applied inputs, outputs sampled 1 ns
    // after the edge and compared against the model.
    task automatic step(input string name);
        model_edge();
        @(posedge clk);
        #1;
        chk({name, "/model"}, {buzzer, alarm_active, snoozing},
            {m_mode == 1, m_mode != 0, m_mode == 2});
    endtask

    // Hand-written step with an explicit expected output triple.
    task automatic hs(input string name, input bit en, input int h, input int m,
                      input bit t, input bit st, input bit sz, input logic [2:0] exp);
        setin(en, h, m, t, st, sz);
        step(name);
        chk(name, {buzzer, alarm_active, snoozing}, exp);
        $display("step %-14s t=%0d stop=%0d snz=%0d en=%0d %02d:%02d -> %b",
                 name, t, st, sz, en, h, m, {buzzer, alarm_active, snoozing});
    endtask

    typedef struct {
        bit         en;
        int         h;
        int         m;
        bit         t;
        bit         st;
        bit         sz;
        logic [2:0] exp;
    } vec_t;

    vec_t vecs[17];

    initial begin
        // Feature-independent table (stop outranks snooze in every build).
        vecs[0]  = '{1, 7, 29, 0, 0, 0, 3'b000};
        vecs[1]  = '{1, 7, 30, 0, 0, 0, 3'b110}; // match edge: ring next edge
        vecs[2]  = '{1, 7, 30, 1, 0, 0, 3'b110};
        vecs[3]  = '{1, 7, 30, 0, 0, 0, 3'b110};
        vecs[4]  = '{1, 7, 30, 1, 0, 0, 3'b110};
        vecs[5]  = '{1, 7, 30, 1, 0, 0, 3'b110};
        vecs[6]  = '{1, 7, 30, 1, 0, 0, 3'b000}; // 4th tick: auto-stop
        vecs[7]  = '{1, 7, 30, 1, 0, 0, 3'b000}; // no retrigger in minute
        vecs[8]  = '{1, 7, 31, 0, 0, 0, 3'b000};
        vecs[9]  = '{1, 7, 30, 0, 0, 0, 3'b110};
        vecs[10] = '{1, 7, 30, 0, 1, 1, 3'b000}; // stop+snooze: stop wins
        vecs[11] = '{1, 7, 29, 0, 0, 0, 3'b000};
        vecs[12] = '{0, 7, 30, 0, 0, 0, 3'b000}; // disarmed at edge
        vecs[13] = '{1, 7, 30, 0, 0, 0, 3'b000}; // armed mid-minute
        vecs[14] = '{1, 7, 31, 0, 0, 0, 3'b000};
        vecs[15] = '{1, 7, 30, 0, 0, 0, 3'b110};
        vecs[16] = '{0, 7, 30, 1, 0, 0, 3'b000}; // disarm aborts ringing

        // Reset state
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        chk("reset_state", {buzzer, alarm_active, snoozing}, 3'b000);
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 17; i++) begin
            hs($sformatf("vec%0d", i), vecs[i].en, vecs[i].h, vecs[i].m,
               vecs[i].t, vecs[i].st, vecs[i].sz, vecs[i].exp);
        end

        // Asynchronous reset mid-ringing, released inside the alarm minute.
        hs("pre_rst_a", 1, 7, 31, 0, 0, 0, 3'b000);
        hs("pre_rst_b", 1, 7, 30, 0, 0, 0, 3'b110);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst", {buzzer, alarm_active, snoozing}, 3'b000);
        model_reset();
        rst = 1'b1;
        hs("post_rst_a", 1, 7, 30, 0, 0, 0, 3'b000);
        hs("post_rst_b", 1, 7, 30, 1, 0, 0, 3'b000);
        hs("post_rst_c", 1, 7, 31, 0, 0, 0, 3'b000);
        hs("post_rst_d", 1, 7, 30, 0, 0, 0, 3'b110);

        if (SNZ_ON) begin
            hs("snz_enter",  1, 7, 30, 0, 0, 1, 3'b011);
            hs("snz_again",  1, 7, 30, 0, 0, 1, 3'b011);
            hs("snz_t1",     1, 7, 30, 1, 0, 0, 3'b011);
            hs("snz_t2",     1, 7, 30, 1, 0, 0, 3'b011);
            hs("snz_t3",     1, 7, 30, 1, 0, 0, 3'b110); // re-ring
            hs("rering_t1",  1, 7, 30, 1, 0, 0, 3'b110);
            hs("rering_t2",  1, 7, 30, 1, 0, 0, 3'b110);
            hs("rering_t3",  1, 7, 30, 1, 0, 0, 3'b110);
            hs("rering_t4",  1, 7, 30, 1, 0, 0, 3'b000);
            hs("snz2_off",   1, 7, 31, 0, 0, 0, 3'b000);
            hs("snz2_ring",  1, 7, 30, 0, 0, 0, 3'b110);
            hs("snz2_enter", 1, 7, 30, 0, 0, 1, 3'b011);
            hs("snz2_stop",  1, 7, 30, 0, 1, 0, 3'b000);
        end else begin
            hs("nosnz_pulse", 1, 7, 30, 0, 0, 1, 3'b110);
            hs("nosnz_t1",    1, 7, 30, 1, 0, 0, 3'b110);
            hs("nosnz_t2",    1, 7, 30, 1, 0, 0, 3'b110);
            hs("nosnz_t3",    1, 7, 30, 1, 0, 0, 3'b110);
            hs("nosnz_t4",    1, 7, 30, 1, 0, 0, 3'b000);
        end

        // Randomized phase against the model only.
        begin
            int cur_min;
            int cur_hr;
            cur_min = 29;
            cur_hr = 7;
            for (int n = 0; n < 3000; n++) begin
                if ($urandom_range(0, 24) == 0) cur_min = $urandom_range(29, 31);
                if ($urandom_range(0, 199) == 0) cur_hr = (cur_hr == 7) ? 8 : 7;
                setin($urandom_range(0, 49) != 0, cur_hr, cur_min,
                      $urandom_range(0, 2) == 0,
                      $urandom_range(0, 39) == 0,
                      $urandom_range(0, 19) == 0);
                step($sformatf("rand%0d", n));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alarm_ctrl.md
ALARM_CTRL -- requirements
Module: alarm_ctrl

Interface
REQ-001 SHALL have parameter RING_SECONDS, default 60, number of tick_1hz pulses the buzzer sounds before auto-stop (>=1).
REQ-002 SHALL have parameter SNOOZE_SECONDS, default 300, number of tick_1hz pulses spent in snooze before re-ringing (>=1).
REQ-003 SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port tick_1hz  input  1  one-cycle pulse once per second, clk-synchronous.
REQ-006 SHALL have port hours  input  5  current hour 0..23 from the hour counter.
REQ-007 SHALL have port minutes  input  6  current minute 0..59 from the minute counter.
REQ-008 SHALL have port alarm_hours  input  5  programmed alarm hour 0..23.
REQ-009 SHALL have port alarm_minutes  input  6  programmed alarm minute 0..59.
REQ-010 SHALL have port alarm_en  input  1  level; alarm armed when high.
REQ-011 SHALL have port stop  input  1  one-cycle debounced pulse; cancels alarm.
REQ-012 SHALL have port snooze  input  1  one-cycle debounced pulse; defers alarm.
REQ-013 SHALL have port buzzer  output  1  high while in RINGING.
REQ-014 SHALL have port alarm_active  output  1  high while in RINGING or SNOOZE.
REQ-015 SHALL have port snoozing  output  1  high while in SNOOZE.

Function
REQ-016 SHALL compute match = (hours==alarm_hours) && (minutes==alarm_minutes) combinationally and register it each cycle as match_q.
REQ-017 SHALL define trigger = alarm_en && match && !match_q (rising edge of match only; enabling alarm_en mid-minute does not trigger).
REQ-018 SHALL implement FSM states IDLE, RINGING, SNOOZE; outputs decoded from registered state only, no combinational path from inputs to outputs.
REQ-019 IDLE: on trigger -> RINGING at next edge, ring_cnt cleared; otherwise stay.
REQ-020 RINGING: ring_cnt increments on each tick_1hz; on tick_1hz with ring_cnt==RING_SECONDS-1 -> IDLE.
REQ-021 RINGING: stop -> IDLE; alarm_en low -> IDLE; snooze (when compiled in) -> SNOOZE with snz_cnt cleared.
REQ-022 SNOOZE: snz_cnt increments on each tick_1hz; on tick_1hz with snz_cnt==SNOOZE_SECONDS-1 -> RINGING with ring_cnt cleared.
REQ-023 SNOOZE: stop -> IDLE; alarm_en low -> IDLE; further snooze pulses ignored (no restart).
REQ-024 Priority within a cycle SHALL be: alarm_en low > stop > snooze > counter expiry.
REQ-025 Trigger SHALL be ignored in RINGING and SNOOZE; after stop or auto-stop within the matching minute no retrigger occurs until match falls and rises again (next day).
REQ-026 ring_cnt and snz_cnt SHALL be sized $clog2 of their parameter (min 1 bit) and SHALL hold when not in their state.
REQ-027 buzzer SHALL rise on the clock edge after the first cycle trigger is sampled true (1-cycle latency).

Reset
REQ-028 On rst low, state SHALL be IDLE, ring_cnt=0, snz_cnt=0, match_q=1, buzzer=0, alarm_active=0, snoozing=0, immediately and asynchronously.
REQ-029 match_q resetting to 1 SHALL prevent a trigger when reset is released during the alarm minute; reset mid-RINGING or mid-SNOOZE SHALL abort to IDLE.

Configuration
REQ-030 Macro ALARM_SNOOZE_EN SHALL, when defined, compile in the SNOOZE state, snz_cnt and SNOOZE_SECONDS behaviour.
REQ-031 Without ALARM_SNOOZE_EN, snooze SHALL be ignored, SNOOZE unreachable, snz_cnt absent, snoozing tied 0; all other behaviour identical.

Verification (bench: RING_SECONDS=4, SNOOZE_SECONDS=3, ALARM_SNOOZE_EN defined unless stated)
REQ-032 alarm 07:30, alarm_en=1, time steps 07:29->07:30 -> buzzer=1 one edge later; after 4 tick_1hz buzzer=0, state IDLE, no retrigger while time stays 07:30.
REQ-033 ringing, snooze pulse -> buzzer=0, snoozing=1, alarm_active=1; after 3 ticks -> buzzer=1, snoozing=0; after 4 more ticks -> IDLE.
REQ-034 ringing, stop and snooze same cycle -> IDLE, all outputs 0; stop during SNOOZE -> IDLE.
REQ-035 alarm_en=0 at 07:29->07:30 then alarm_en=1 at 07:30 -> no ring; rst low mid-RINGING then released at 07:30 -> outputs 0, no ring until next match edge.
REQ-036 ALARM_SNOOZE_EN undefined: ringing, snooze pulse -> buzzer stays 1, snoozing=0; auto-stop after 4 ticks.
